// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU-side port.
package vdp_pkg;

  // Register indices with fixed meaning
  localparam int R_MODE0 = 0;
  localparam int R_MODE1 = 1;
  localparam int R_EXT   = 14;
  localparam int R_EXTFN = 31;

  // Status byte layout: {F, C, 5S, num[4:0]}
  localparam int ST_F  = 7;
  localparam int ST_C  = 6;
  localparam int ST_5S = 5;

  // Frame-interrupt enable bit inside R_MODE1
  localparam int INT_EN_BIT = 5;

  // Default parameter values
  localparam int DEF_ADDR_W  = 14;
  localparam int DEF_NREGS   = 8;
  localparam int DEF_EXT_REG = R_EXT;
  localparam int DEF_DEPTH   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WR   = 2'd1,
    ARB_RD   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       f;
    logic       c;
    logic       s5;
    logic [4:0] num;
  } vdp_status_t;

endpackage

// File: rtl/vdp_wfifo.sv
// Generic synchronous FIFO with occupancy output; storage is not reset.
module vdp_wfifo #(
  parameter int W     = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clk40m,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;

  assign level = wp - rp;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wp == rp);
  assign dout  = mem[rp[AW-1:0]];

  // Pointer update; one extra bit distinguishes full from empty
  always_ff @(posedge clk40m or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  // Entry storage
  always_ff @(posedge clk40m) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vdp_cpu_ext.sv
// CPU-side port: I/O decode, ctrl/data port protocol, register file,
// status/interrupt, posted VRAM writes and read prefetch.
module vdp_cpu_ext
  import vdp_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NREGS   = DEF_NREGS,
  parameter int EXT_REG = DEF_EXT_REG,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                      clk40m,
  input  logic                      rst_n,
  input  logic [7:0]                cpu_a,
  input  logic [7:0]                cpu_din,
  input  logic                      cpu_in_n,
  input  logic                      cpu_out_n,
  input  logic [7:0]                data_port,
  input  logic [7:0]                ctrl_port,
  output logic [7:0]                cpu_dout,
  output logic                      cpu_doe,
  output logic                      cpu_int_n,
  output logic                      cpu_wait_n,
  output logic                      vram_req,
  input  logic                      vram_ack,
  output logic                      vram_wr,
  output logic [ADDR_W-1:0]         vram_a,
  output logic [7:0]                vram_wdata,
  input  logic [7:0]                vram_rdata,
  output logic [NREGS*8-1:0]        regs,
  output logic [NREGS*8-1:0]        regs_frame,
  input  logic                      set_mode,
  input  logic                      start_vblank,
  input  logic                      spr_collide,
  input  logic                      spr_5,
  input  logic [4:0]                spr_5num,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      ovf
);
  localparam int FW = ADDR_W + 8;

  // Select vector: [0] data out, [1] ctrl out, [2] data in, [3] ctrl in
  logic [3:0] sel_raw, s1, s2, s3, rise, fall;
  assign sel_raw = {(cpu_a == ctrl_port) & ~cpu_in_n,
                    (cpu_a == data_port) & ~cpu_in_n,
                    (cpu_a == ctrl_port) & ~cpu_out_n,
                    (cpu_a == data_port) & ~cpu_out_n};
  assign cpu_doe = sel_raw[2] | sel_raw[3];

  // Two-flop synchroniser plus an edge-detect stage
  always_ff @(posedge clk40m or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= sel_raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  logic wr_data, wr_ctrl, rd_data, rd_ctrl, snap_stb;
  assign wr_data  = rise[0];
  assign wr_ctrl  = rise[1];
  assign rd_data  = fall[2];
  assign rd_ctrl  = fall[3];
  assign snap_stb = rise[3];

  // Port state
  logic [NREGS-1:0][7:0] regs_q, regs_frame_q;
  logic [ADDR_W-1:0]     addr_q, addr_nxt, set_addr;
  logic [7:0]            latch_q, rdbuf;
  logic                  byte2, pf_pend, pf_nxt, cancel_q;
  vdp_status_t           st, snap;
  arb_state_t            state;

  // FIFO hookup
  logic [FW-1:0] head;
  logic          full, empty, push, pop, rd_ack, issue_rd, rd_busy, rd_ok;
  logic          addr_set, reg_wr;

  assign addr_set = wr_ctrl & byte2 & ~cpu_din[7];
  assign reg_wr   = wr_ctrl & byte2 & cpu_din[7];
  assign push     = wr_data & ~full;
  assign pop      = (state == ARB_WR) & vram_ack;
  assign rd_ack   = (state == ARB_RD) & vram_ack;
  assign issue_rd = (state == ARB_IDLE) & empty & pf_pend;
  assign rd_busy  = (state == ARB_RD) | issue_rd;
  // A read overtaken by an address-set must not touch rdbuf or addr
  assign rd_ok    = rd_ack & ~cancel_q & ~addr_set;

  vdp_wfifo #(.W(FW), .DEPTH(DEPTH)) u_wfifo (
    .clk40m (clk40m),
    .rst_n  (rst_n),
    .push   (push),
    .din    ({addr_q, cpu_din}),
    .pop    (pop),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );

  // Address-set value; upper bits come from the extension register
  generate
    if (ADDR_W > 14 && EXT_REG < NREGS) begin : g_ext
      assign set_addr = {regs_q[EXT_REG][ADDR_W-15:0], cpu_din[5:0], addr_q[7:0]};
    end else if (ADDR_W > 14) begin : g_ext0
      assign set_addr = {{(ADDR_W-14){1'b0}}, cpu_din[5:0], addr_q[7:0]};
    end else begin : g_base
      assign set_addr = {cpu_din[5:0], addr_q[7:0]};
    end
  endgenerate

  // Next VRAM address: address-set overrides, otherwise writes and reads advance it
  always_comb begin
    addr_nxt = addr_q;
    if (addr_set) begin
      addr_nxt = set_addr;
    end else begin
      addr_nxt = addr_q + ADDR_W'(push) + ADDR_W'(rd_ok);
      if (wr_ctrl && !byte2) addr_nxt[7:0] = cpu_din;
    end
  end

  // Prefetch request; merges with one already queued or in flight
  always_comb begin
    pf_nxt = pf_pend & ~issue_rd;
    if (addr_set)
      pf_nxt = ~cpu_din[6];
    else if (rd_data && !(rd_busy && !cancel_q))
      pf_nxt = 1'b1;
  end

  // CPU-side protocol, register file, status and overflow
  always_ff @(posedge clk40m or negedge rst_n) begin
    if (!rst_n) begin
      byte2        <= 1'b0;
      latch_q      <= '0;
      addr_q       <= '0;
      regs_q       <= '0;
      regs_frame_q <= '0;
      rdbuf        <= '0;
      pf_pend      <= 1'b0;
      cancel_q     <= 1'b0;
      ovf          <= 1'b0;
      st           <= '0;
      snap         <= '0;
    end else begin
      if (wr_ctrl)                          byte2 <= ~byte2;
      else if (wr_data | rd_data | rd_ctrl) byte2 <= 1'b0;

      if (wr_ctrl && !byte2) latch_q <= cpu_din;
      addr_q  <= addr_nxt;
      pf_pend <= pf_nxt;

      if (reg_wr)
        for (int i = 0; i < NREGS; i++)
          if (cpu_din[4:0] == 5'(i)) regs_q[i] <= latch_q;

      if (set_mode) regs_frame_q <= regs_q;

      if (push)       rdbuf <= cpu_din;
      else if (rd_ok) rdbuf <= vram_rdata;

      if (rd_ack)                    cancel_q <= 1'b0;
      else if (addr_set && rd_busy)  cancel_q <= 1'b1;

      if (wr_data && full) ovf <= 1'b1;
      else if (rd_ctrl)    ovf <= 1'b0;

      // Frame start beats a same-cycle status clear
      if (start_vblank) begin
        st.f   <= 1'b1;
        st.c   <= spr_collide;
        st.s5  <= spr_5;
        st.num <= spr_5num;
      end else if (rd_ctrl) begin
        st.f  <= 1'b0;
        st.c  <= 1'b0;
        st.s5 <= 1'b0;
      end

      if (snap_stb) snap <= st;
    end
  end

  // VRAM arbiter: writes drain before any prefetch; request held until ack
  always_ff @(posedge clk40m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      vram_req   <= 1'b0;
      vram_wr    <= 1'b0;
      vram_a     <= '0;
      vram_wdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (!empty) begin
            state      <= ARB_WR;
            vram_req   <= 1'b1;
            vram_wr    <= 1'b1;
            vram_a     <= head[FW-1:8];
            vram_wdata <= head[7:0];
          end else if (pf_pend) begin
            state    <= ARB_RD;
            vram_req <= 1'b1;
            vram_wr  <= 1'b0;
            vram_a   <= addr_q;
          end
        end
        ARB_WR, ARB_RD: begin
          if (vram_ack) begin
            state    <= ARB_IDLE;
            vram_req <= 1'b0;
            vram_wr  <= 1'b0;
          end
        end
        default: begin
          state    <= ARB_IDLE;
          vram_req <= 1'b0;
          vram_wr  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_dout   = (cpu_a == ctrl_port) ? snap : rdbuf;
  assign cpu_int_n  = ~(st.f & regs_q[R_MODE1][INT_EN_BIT]);
  assign cpu_wait_n = ~full;
  assign regs       = regs_q;
  assign regs_frame = regs_frame_q;

endmodule
